// File: rtl/rob_id_allocator.sv
// rob_id_allocator: ROB head/tail/occupancy tracker for a dual-issue core.
// Allocates up to two ROB ids per cycle and reclaims up to two per cycle
// on in-order commit; a flush squashes every uncommitted entry.
// Optional build macro ROB_ALLOC_CHECK_EN adds sticky alloc_err/commit_err
// outputs that flag clamped or malformed requests.
//
// Handshake: there is no backpressure. Dispatch compares rob_left against its
// valid-instruction count before raising alloc*_valid; any request beyond the
// free space is silently dropped (and flagged when ROB_ALLOC_CHECK_EN is set).
module rob_id_allocator #(
  parameter int ROB_AW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alloc0_valid,
  input  logic              alloc1_valid,
  output logic [ROB_AW:0]   robid0,
  output logic [ROB_AW:0]   robid1,
  output logic [1:0]        rob_left,
  input  logic              commit0_valid,
  input  logic              commit1_valid,
  input  logic              flush_valid,
  output logic [ROB_AW:0]   head_id,
  output logic              rob_empty,
  output logic              rob_full
`ifdef ROB_ALLOC_CHECK_EN
  ,
  output logic              alloc_err,
  output logic              commit_err
`endif
);

  // IW: pointer/id width including the wrap bit. CW: one extra bit so that
  // DEPTH - occ + n_commit can be formed without overflow.
  localparam int IW    = ROB_AW + 1;
  localparam int CW    = ROB_AW + 2;
  localparam int DEPTH = 1 << ROB_AW;
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  logic [IW-1:0] head;
  logic [IW-1:0] tail;
  logic [IW-1:0] occ;

  logic [CW-1:0] occ_w;
  logic [CW-1:0] commit_req;
  logic [CW-1:0] n_commit;
  logic [CW-1:0] alloc_req;
  logic [CW-1:0] alloc_cap;
  logic [CW-1:0] n_alloc;
  logic [CW-1:0] free_cnt;
  logic [IW-1:0] head_next;
  logic [IW-1:0] tail_next;
  logic [IW-1:0] occ_next;

  // Request decode, clamping and next-state computation.
  always_comb begin
    occ_w      = {1'b0, occ};
    commit_req = CW'(commit0_valid) + CW'(commit0_valid & commit1_valid);
    n_commit   = (commit_req > occ_w) ? occ_w : commit_req;
    alloc_req  = CW'(alloc0_valid) + CW'(alloc1_valid);
    // Entries retired this cycle may be reused by this cycle's allocations.
    alloc_cap  = DEPTH_W - occ_w + n_commit;
    n_alloc    = (alloc_req > alloc_cap) ? alloc_cap : alloc_req;
    head_next  = head + n_commit[IW-1:0];
    if (flush_valid) begin
      // Commits still retire; everything younger is squashed.
      tail_next = head_next;
      occ_next  = '0;
    end else begin
      tail_next = tail + n_alloc[IW-1:0];
      occ_next  = occ + n_alloc[IW-1:0] - n_commit[IW-1:0];
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      occ  <= '0;
    end else begin
      head <= head_next;
      tail <= tail_next;
      occ  <= occ_next;
    end
  end

  // Outputs decoded from registered state (robid1 also looks at alloc0_valid).
  always_comb begin
    free_cnt  = DEPTH_W - occ_w;
    robid0    = tail;
    robid1    = alloc0_valid ? (tail + IW'(1)) : tail;
    head_id   = head;
    rob_left  = (free_cnt >= CW'(3)) ? 2'd3 : free_cnt[1:0];
    rob_empty = (occ == '0);
    rob_full  = (occ_w == DEPTH_W);
  end

`ifdef ROB_ALLOC_CHECK_EN
  logic alloc_bad;
  logic commit_bad;

  // Malformed or clamped requests; allocations are ignored during a flush.
  always_comb begin
    alloc_bad  = ~flush_valid & ((n_alloc != alloc_req) | (alloc1_valid & ~alloc0_valid));
    commit_bad = (n_commit != commit_req) | (commit1_valid & ~commit0_valid);
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      alloc_err  <= 1'b0;
      commit_err <= 1'b0;
    end else begin
      if (alloc_bad) begin
        alloc_err <= 1'b1;
        if (!alloc_err) $error("rob_id_allocator: allocation clamped or slot-1 only");
      end
      if (commit_bad) begin
        commit_err <= 1'b1;
        if (!commit_err) $error("rob_id_allocator: commit clamped or slot-1 only");
      end
    end
  end
`endif

endmodule
